// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame layout
// and the default text-segment base address.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;
  localparam int          HEADER_BYTES         = 2;
  localparam int          CHECKSUM_WIDTH       = 8;
  localparam int          LEN_WIDTH            = 8 * HEADER_BYTES;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembler. Holds the bytes received so far for the
// current word; o_word_next presents the complete word (held bytes plus the
// incoming byte) so the caller can capture it on the same edge the last byte
// is accepted. o_word_complete flags that final byte.
module word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_shift_en,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_word_next,
  output logic                  o_word_complete
);

  localparam int HELD_W = DATA_WIDTH - 8;

  logic [HELD_W-1:0] r_held;
  logic [1:0]        r_count;

  assign o_word_next     = {r_held, i_byte};
  assign o_word_complete = i_shift_en && (r_count == 2'd3);

  // Shift accepted bytes in MSB-first; clear drops any partial word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_held  <= '0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_held  <= '0;
      r_count <= 2'd0;
    end else if (i_shift_en) begin
      r_held  <= o_word_next[HELD_W-1:0];
      r_count <= r_count + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (16-bit word count, data
// bytes, XOR checksum), writes big-endian words into program memory at
// consecutive text-segment addresses and keeps the CPU in reset until a
// verified image is in place.
//
// Handshake: a byte moves when byte_valid && byte_ready are both high at a
// rising clock edge; byte_ready depends only on the current state, so the
// source may hold byte_valid high indefinitely and no byte is ever dropped.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 2048,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output state_t                state_dbg
);

  // One extra bit so an index equal to MEMORY_DEPTH is representable.
  localparam int IDX_W = $clog2(MEMORY_DEPTH) + 1;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [7:0]                r_len_hi;
  logic [LEN_WIDTH-1:0]      r_len;
  logic [IDX_W-1:0]          r_index;
  logic [CHECKSUM_WIDTH-1:0] r_csum;
  logic [DATA_WIDTH-1:0]     r_mem_address;
  logic [DATA_WIDTH-1:0]     r_mem_data;

  logic                      w_byte_ready;
  logic                      w_write_en;
  logic                      w_clear;
  logic                      w_shift;
  logic                      w_xfer;
  logic [LEN_WIDTH-1:0]      w_len_in;
  logic [IDX_W-1:0]          w_index_inc;
  logic [DATA_WIDTH-1:0]     w_word_next;
  logic                      w_word_complete;
  logic [DATA_WIDTH-1:0]     w_word_address;

  assign w_xfer         = byte_valid && w_byte_ready;
  assign w_len_in       = {r_len_hi, byte_data};
  assign w_index_inc    = r_index + 1'b1;
  assign w_word_address = BASE_ADDRESS + DATA_WIDTH'({r_index, 2'b00});

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_clear         (w_clear),
    .i_shift_en      (w_shift),
    .i_byte          (byte_data),
    .o_word_next     (w_word_next),
    .o_word_complete (w_word_complete)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-state strobes; start is only honoured when idle or finished.
  always_comb begin
    w_next_state = r_state;
    w_byte_ready = 1'b0;
    w_write_en   = 1'b0;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_next_state = S_LEN_HI;
          w_clear      = 1'b1;
        end
      end
      S_LEN_HI: begin
        w_byte_ready = 1'b1;
        if (w_xfer) w_next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_byte_ready = 1'b1;
        if (w_xfer) begin
          if (w_len_in == '0)
            w_next_state = S_CHECK;
          else if (32'(w_len_in) > 32'(MEMORY_DEPTH))
            w_next_state = S_ERROR;
          else
            w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        w_byte_ready = 1'b1;
        w_shift      = w_xfer;
        if (w_word_complete) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        w_write_en   = 1'b1;
        w_next_state = (32'(w_index_inc) == 32'(r_len)) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        w_byte_ready = 1'b1;
        if (w_xfer) w_next_state = (byte_data == r_csum) ? S_DONE : S_ERROR;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Frame bookkeeping: length capture, running checksum, word index and the
  // write-port address/data, which are captured with the last byte of a word
  // and then held until the next word is complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_hi      <= '0;
      r_len         <= '0;
      r_index       <= '0;
      r_csum        <= '0;
      r_mem_address <= BASE_ADDRESS;
      r_mem_data    <= '0;
    end else begin
      if (w_clear) begin
        r_len   <= '0;
        r_index <= '0;
        r_csum  <= '0;
      end
      if (r_state == S_LEN_HI && w_xfer) r_len_hi <= byte_data;
      if (r_state == S_LEN_LO && w_xfer) r_len    <= w_len_in;
      if (w_shift) r_csum <= r_csum ^ byte_data;
      if (w_word_complete) begin
        r_mem_address <= w_word_address;
        r_mem_data    <= w_word_next;
      end
      if (r_state == S_WRITE) r_index <= w_index_inc;
    end
  end

  assign byte_ready       = w_byte_ready;
  assign mem_write_enable = w_write_en;
  assign mem_address      = r_mem_address;
  assign mem_write_data   = r_mem_data;
  assign done             = (r_state == S_DONE);
  assign error            = (r_state == S_ERROR);
  assign cpu_hold         = (r_state != S_DONE);
  assign state_dbg        = r_state;

endmodule
